// File: rtl/ring_arb_pkg.sv
// Shared types and helpers for the ring-token round-robin arbiter.
package ring_arb_pkg;

  localparam int N_DEF       = 8;
  localparam int QUANTUM_DEF = 4;

  // Widest requester vector the helper functions accept.
  localparam int MAX_N = 64;

  typedef logic [MAX_N-1:0] word_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Rotate the low n bits of x left by one, bit n-1 wrapping into bit 0.
  function automatic word_t rotl(input word_t x, input int n);
    word_t r;
    r = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (i < n) begin
        r[(i + 1) % n] = x[i];
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Binary index of a one-hot vector; zero when no bit is set.
  function automatic logic [5:0] onehot2bin(input word_t x);
    logic [5:0] r;
    r = 6'd0;
    for (int i = 0; i < MAX_N; i++) begin
      if (x[i]) begin
        r = r | 6'(i);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set bit of req at or above the
// token position, wrapping from N-1 back to 0.
module rr_pick
  import ring_arb_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] token,
  output logic [N-1:0] pick
);

  logic [N-1:0]   mask_s;
  logic [2*N-1:0] dbl_s;
  logic           found_s;

  // Lower copy only keeps requests at/above the token, upper copy supplies the wrap.
  always_comb begin
    mask_s  = ~(token - {{(N-1){1'b0}}, 1'b1});
    dbl_s   = {req, req & mask_s};
    pick    = '0;
    found_s = 1'b0;
    for (int i = 0; i < 2*N; i++) begin
      if (dbl_s[i] && !found_s) begin
        pick[i % N] = 1'b1;
        found_s     = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/ring_token_arbiter.sv
// Round-robin arbiter with a one-hot rotating priority token and a
// bounded grant quantum. All outputs come straight from registers.
module ring_token_arbiter
  import ring_arb_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int QUANTUM = QUANTUM_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic                 gnt_valid,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic [N-1:0]         token
);

  localparam int IDW = $clog2(N);
  localparam int HCW = $clog2(QUANTUM) + 1;

  state_t         state_r, state_n_s;
  logic [N-1:0]   gnt_r, gnt_n_s;
  logic [N-1:0]   token_r, token_n_s;
  logic [HCW-1:0] hold_cnt_r, hold_n_s;
  logic           gnt_valid_r;
  logic [IDW-1:0] gnt_id_r, id_n_s;

  logic [N-1:0]   rot_gnt_s;
  logic [N-1:0]   search_tok_s;
  logic [N-1:0]   pick_s;
  logic           release_s;

  // Next token candidate; the current owner ends up searched last.
  assign rot_gnt_s    = N'(rotl(word_t'(gnt_r), N));
  assign search_tok_s = (state_r == GRANT) ? rot_gnt_s : token_r;
  assign release_s    = !(|(req & gnt_r)) || (hold_cnt_r == HCW'(QUANTUM - 1));
  assign id_n_s       = IDW'(onehot2bin(word_t'(gnt_n_s)));

  rr_pick #(.N(N)) u_pick (
    .req   (req),
    .token (search_tok_s),
    .pick  (pick_s)
  );

  // Next-state, grant, token and hold-count decisions.
  always_comb begin
    state_n_s = state_r;
    gnt_n_s   = gnt_r;
    token_n_s = token_r;
    hold_n_s  = hold_cnt_r;
    case (state_r)
      IDLE: begin
        if (|req) begin
          gnt_n_s   = pick_s;
          hold_n_s  = '0;
          state_n_s = GRANT;
        end else begin
          gnt_n_s   = '0;
          state_n_s = IDLE;
        end
      end
      GRANT: begin
        if (release_s) begin
          token_n_s = rot_gnt_s;
          gnt_n_s   = pick_s;
          hold_n_s  = '0;
          state_n_s = (|pick_s) ? GRANT : IDLE;
        end else begin
          hold_n_s  = hold_cnt_r + HCW'(1);
        end
      end
      default: begin
        state_n_s = IDLE;
        gnt_n_s   = '0;
        hold_n_s  = '0;
      end
    endcase
  end

  // State, grant, token and registered grant encodings.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      gnt_r       <= '0;
      token_r     <= {{(N-1){1'b0}}, 1'b1};
      hold_cnt_r  <= '0;
      gnt_valid_r <= 1'b0;
      gnt_id_r    <= '0;
    end else begin
      state_r     <= state_n_s;
      gnt_r       <= gnt_n_s;
      token_r     <= token_n_s;
      hold_cnt_r  <= hold_n_s;
      gnt_valid_r <= |gnt_n_s;
      gnt_id_r    <= id_n_s;
    end
  end

  assign gnt       = gnt_r;
  assign gnt_valid = gnt_valid_r;
  assign gnt_id    = gnt_id_r;
  assign token     = token_r;

endmodule
